// File: rtl/compare_window_monitor_if.sv
// rtl/compare_window_monitor_if.sv - sample and report handshake bundle for compare_window_monitor
interface compare_window_monitor_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             less;
    logic             equal;
    logic             bigger;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_less;
    logic [CNT_W-1:0] cnt_equal;
    logic [CNT_W-1:0] cnt_bigger;
    logic [WIDTH-1:0] max_in1;
    logic             err_flags;
    logic             err_cmp;

    modport master (
        output in_valid, in1, in2, less, equal, bigger, out_ready,
        input  in_ready, out_valid, cnt_less, cnt_equal, cnt_bigger, max_in1, err_flags, err_cmp
    );

    modport slave (
        input  in_valid, in1, in2, less, equal, bigger, out_ready,
        output in_ready, out_valid, cnt_less, cnt_equal, cnt_bigger, max_in1, err_flags, err_cmp
    );
endinterface

// File: rtl/compare_window_monitor.sv
// rtl/compare_window_monitor.sv - windowed statistics over compare samples; CMP_CHECK_EN adds a relation recheck
module compare_window_monitor #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    compare_window_monitor_if.slave   bus
);
    localparam int SCNT_W = $clog2(WINDOW + 1);

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [SCNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0]  cnt_less_q;
    logic [CNT_W-1:0]  cnt_equal_q;
    logic [CNT_W-1:0]  cnt_bigger_q;
    logic [WIDTH-1:0]  max_q;
    logic              err_flags_q;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              accept;
    logic              last_sample;
    logic              report_done;
    logic [2:0]        flags;
    logic              flags_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign flags       = {bus.less, bus.equal, bus.bigger};
    assign flags_bad   = !((flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001));
    assign accept      = bus.in_valid & in_ready_c;
    assign last_sample = (sample_cnt == SCNT_W'(WINDOW - 1));
    assign report_done = out_valid_c & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_sample) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
        // clear outranks both the closing accept and the report handshake
        if (clear) begin
            state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt   <= '0;
            cnt_less_q   <= '0;
            cnt_equal_q  <= '0;
            cnt_bigger_q <= '0;
            max_q        <= '0;
            err_flags_q  <= 1'b0;
        end else if (clear) begin
            sample_cnt   <= '0;
            cnt_less_q   <= '0;
            cnt_equal_q  <= '0;
            cnt_bigger_q <= '0;
            max_q        <= '0;
            err_flags_q  <= 1'b0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + SCNT_W'(1);
            if (bus.less)   cnt_less_q   <= sat_inc(cnt_less_q);
            if (bus.equal)  cnt_equal_q  <= sat_inc(cnt_equal_q);
            if (bus.bigger) cnt_bigger_q <= sat_inc(cnt_bigger_q);
            if ((sample_cnt == '0) || (bus.in1 > max_q)) begin
                max_q <= bus.in1;
            end
            if (flags_bad) begin
                err_flags_q <= 1'b1;
            end
        end else if (report_done) begin
            // error flags are sticky across reports
            sample_cnt   <= '0;
            cnt_less_q   <= '0;
            cnt_equal_q  <= '0;
            cnt_bigger_q <= '0;
            max_q        <= '0;
        end
    end

`ifdef CMP_CHECK_EN
    logic       err_cmp_q;
    logic [2:0] relation;

    assign relation = {bus.in1 < bus.in2, bus.in1 == bus.in2, bus.in1 > bus.in2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cmp_q <= 1'b0;
        end else if (clear) begin
            err_cmp_q <= 1'b0;
        end else if (accept && (flags != relation)) begin
            err_cmp_q <= 1'b1;
        end
    end

    assign bus.err_cmp = err_cmp_q;
`else
    assign bus.err_cmp = 1'b0;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.cnt_less   = cnt_less_q;
    assign bus.cnt_equal  = cnt_equal_q;
    assign bus.cnt_bigger = cnt_bigger_q;
    assign bus.max_in1    = max_q;
    assign bus.err_flags  = err_flags_q;
endmodule
